cvm_dispense_ctrl: RTL

// Downstream stage of the coin-vending FSM: consumes its del/rn/rd strobes and drives the product

---
 rtl/cvm_dispense_ctrl.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cvm_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cvm_dispense_ctrl
// Purpose  : Dispense stage behind the coin-vending FSM. Queues del/rn/rd
//            strobes as pending counts and serialises them into timed
//            product-motor and nickel/dime ejector pulses. Tracks product,
//            nickel and dime stock, and flags sold-out, exact-change-only
//            and mechanical faults.
// Ports    : clk, rst (async, active-high)
//            del, rn, rd        request strobes, one request per high cycle
//            vend_done          chute sensor, product has dropped
//            refill, refill_*   one-cycle load of the three stock counters
//            fault_clr          clears fault, leaves S_FAULT
//            motor, eject_n, eject_d   actuator drives
//            busy, fault, sold_out, exact_change   status
//            prod_cnt, nick_cnt, dime_cnt          stock counts
// Revision : 1.0 - initial release
// ============================================================================
module cvm_dispense_ctrl #(
  parameter int MOTOR_CYC = 8,
  parameter int EJECT_CYC = 4,
  parameter int TIMEOUT   = 64,
  parameter int STOCK_W   = 8,
  parameter int PEND_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               del,
  input  logic               rn,
  input  logic               rd,
  input  logic               vend_done,
  input  logic               refill,
  input  logic [STOCK_W-1:0] refill_prod,
  input  logic [STOCK_W-1:0] refill_nick,
  input  logic [STOCK_W-1:0] refill_dime,
  input  logic               fault_clr,
  output logic               motor,
  output logic               eject_n,
  output logic               eject_d,
  output logic               busy,
  output logic               fault,
  output logic               sold_out,
  output logic               exact_change,
  output logic [STOCK_W-1:0] prod_cnt,
  output logic [STOCK_W-1:0] nick_cnt,
  output logic [STOCK_W-1:0] dime_cnt
);

  // Index of each request channel in the pending/stock arrays.
  localparam int C_PROD = 0;
  localparam int C_NICK = 1;
  localparam int C_DIME = 2;

  // The shared phase timer must reach the longest of the three durations.
  localparam int C_TMAX =
    (TIMEOUT > MOTOR_CYC) ? ((TIMEOUT > EJECT_CYC) ? TIMEOUT : EJECT_CYC)
                          : ((MOTOR_CYC > EJECT_CYC) ? MOTOR_CYC : EJECT_CYC);
  localparam int C_TMR_W = $clog2(C_TMAX + 1);

  localparam logic [C_TMR_W-1:0] c_motor_last = C_TMR_W'(MOTOR_CYC - 1);
  localparam logic [C_TMR_W-1:0] c_eject_last = C_TMR_W'(EJECT_CYC - 1);
  localparam logic [C_TMR_W-1:0] c_wait_last  = C_TMR_W'(TIMEOUT - 1);
  localparam logic [C_TMR_W-1:0] c_tmr_one    = C_TMR_W'(1);
  localparam logic [PEND_W-1:0]  c_pend_max   = '1;
  localparam logic [PEND_W-1:0]  c_pend_one   = PEND_W'(1);
  localparam logic [STOCK_W-1:0] c_stock_one  = STOCK_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOTOR = 3'd1,
    S_WAIT  = 3'd2,
    S_EJD   = 3'd3,
    S_EJN   = 3'd4,
    S_GAP   = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_TMR_W-1:0]   r_tmr;
  logic [PEND_W-1:0]    r_pend      [3];
  logic [PEND_W-1:0]    w_pend_nxt  [3];
  logic [STOCK_W-1:0]   r_stock     [3];
  logic [STOCK_W-1:0]   w_refill_val[3];
  logic [2:0]           w_req;
  logic [2:0]           w_deq;
  logic [2:0]           w_dec;
  logic [2:0]           w_sat;
  logic                 w_fsm_fault;
  logic                 r_fault;

  assign w_req           = {rd, rn, del};
  assign w_refill_val[0] = refill_prod;
  assign w_refill_val[1] = refill_nick;
  assign w_refill_val[2] = refill_dime;

  // --------------------------------------------------------------------------
  // Pending request counters: pend <= pend + in - deq. An increment that
  // would overflow is dropped and raises fault; with a same-cycle dequeue the
  // net change is zero, so that case is never an overflow.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sat = '0;
    for (int i = 0; i < 3; i++) begin
      w_pend_nxt[i] = r_pend[i];
      if (w_req[i] && !w_deq[i]) begin
        if (r_pend[i] == c_pend_max) begin
          w_sat[i] = 1'b1;
        end else begin
          w_pend_nxt[i] = r_pend[i] + c_pend_one;
        end
      end else if (!w_req[i] && w_deq[i]) begin
        w_pend_nxt[i] = r_pend[i] - c_pend_one;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_pend[i] <= w_pend_nxt[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stock counters. Refill wins over a same-cycle vend decrement. The FSM
  // only decrements a nonzero count, so these cannot wrap below zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_stock[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (refill) begin
          r_stock[i] <= w_refill_val[i];
        end else if (w_dec[i]) begin
          r_stock[i] <= r_stock[i] - c_stock_one;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky fault. A new fault event in the same cycle as fault_clr wins so
  // that event is not lost.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_fsm_fault || (|w_sat)) begin
      r_fault <= 1'b1;
    end else if (fault_clr) begin
      r_fault <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register and phase timer. The timer restarts on every state
  // change, so in each timed state it holds the cycle index within the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_tmr <= '0;
      end else begin
        r_tmr <= r_tmr + c_tmr_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and drive decode. Drives are decoded from the state
  // register, so an asynchronous reset drops them at once.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_deq       = '0;
    w_dec       = '0;
    w_fsm_fault = 1'b0;
    motor       = 1'b0;
    eject_n     = 1'b0;
    eject_d     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Priority product > dime > nickel. An empty stock still consumes
        // the request but only raises fault and takes the gap cycle.
        if (r_pend[C_PROD] != '0) begin
          w_deq[C_PROD] = 1'b1;
          if (r_stock[C_PROD] == '0) begin
            w_fsm_fault = 1'b1;
            w_state_nxt = S_GAP;
          end else begin
            w_dec[C_PROD] = 1'b1;
            w_state_nxt   = S_MOTOR;
          end
        end else if (r_pend[C_DIME] != '0) begin
          w_deq[C_DIME] = 1'b1;
          if (r_stock[C_DIME] == '0) begin
            w_fsm_fault = 1'b1;
            w_state_nxt = S_GAP;
          end else begin
            w_dec[C_DIME] = 1'b1;
            w_state_nxt   = S_EJD;
          end
        end else if (r_pend[C_NICK] != '0) begin
          w_deq[C_NICK] = 1'b1;
          if (r_stock[C_NICK] == '0) begin
            w_fsm_fault = 1'b1;
            w_state_nxt = S_GAP;
          end else begin
            w_dec[C_NICK] = 1'b1;
            w_state_nxt   = S_EJN;
          end
        end
      end
      S_MOTOR: begin
        motor = 1'b1;
        if (r_tmr == c_motor_last) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (vend_done) begin
          w_state_nxt = S_GAP;
        end else if (r_tmr == c_wait_last) begin
          w_fsm_fault = 1'b1;
          w_state_nxt = S_FAULT;
        end
      end
      S_EJD: begin
        eject_d = 1'b1;
        if (r_tmr == c_eject_last) begin
          w_state_nxt = S_GAP;
        end
      end
      S_EJN: begin
        eject_n = 1'b1;
        if (r_tmr == c_eject_last) begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Status outputs
  // --------------------------------------------------------------------------
  assign fault        = r_fault;
  assign busy         = (r_state != S_IDLE) || (r_pend[C_PROD] != '0) ||
                        (r_pend[C_NICK] != '0) || (r_pend[C_DIME] != '0);
  assign prod_cnt     = r_stock[C_PROD];
  assign nick_cnt     = r_stock[C_NICK];
  assign dime_cnt     = r_stock[C_DIME];
  assign sold_out     = (r_stock[C_PROD] == '0);
  assign exact_change = (r_stock[C_NICK] == '0) || (r_stock[C_DIME] == '0);

endmodule
`default_nettype wire
